// File: rtl/card_pkg.sv
// Shared FSM state type, LFSR constants and default deck geometry for card_deck_engine.
package card_pkg;

    localparam int N_CARDS_DEF = 16;
    localparam int CARD_W_DEF  = 5;

    // Tap masks: bit k-1 set for each x^k term; feedback enters at bit 0.
    localparam logic [15:0] LFSR_TAPS_8  = 16'h00B8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
    localparam logic [15:0] LFSR_RST_8   = 16'h00FE;
    localparam logic [15:0] LFSR_RST_16  = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHUF = 2'd1,
        PICK = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [15:0] lfsr_taps(input int w);
        return (w == 16) ? LFSR_TAPS_16 : LFSR_TAPS_8;
    endfunction

    function automatic logic [15:0] lfsr_rst_val(input int w);
        return (w == 16) ? LFSR_RST_16 : LFSR_RST_8;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Maximal-length Fibonacci LFSR (8 or 16 bits) with optional parallel load; never holds zero.
module lfsr_gen
    import card_pkg::*;
#(
    parameter int LFSR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [LFSR_W-1:0] SEED = LFSR_W'(lfsr_rst_val(LFSR_W));

    logic [LFSR_W-1:0] q_r;
    logic [LFSR_W-1:0] next_s;

    // Next value: a load wins over shifting, and a zero load maps to the reset seed.
    always_comb begin
        next_s = {q_r[LFSR_W-2:0], ^(q_r & TAPS)};
        if (load) begin
            if (load_val == {LFSR_W{1'b0}}) begin
                next_s = SEED;
            end else begin
                next_s = load_val;
            end
        end else begin
            next_s = {q_r[LFSR_W-2:0], ^(q_r & TAPS)};
        end
    end

    // Generator state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= SEED;
        end else begin
            q_r <= next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/card_deck_engine.sv
// Memory-game deck engine: Fisher-Yates shuffle and random eligible-card pick.
// Optional macro CARD_SEED_LOAD_EN adds seed_load/seed_in ports to reseed the LFSR.
module card_deck_engine
    import card_pkg::*;
#(
    parameter  int N_CARDS = N_CARDS_DEF,
    parameter  int CARD_W  = CARD_W_DEF,
    parameter  int LFSR_W  = 8,
    localparam int IDX_W   = $clog2(N_CARDS)
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef CARD_SEED_LOAD_EN
    input  logic                           seed_load,
    input  logic [LFSR_W-1:0]              seed_in,
`endif
    input  logic                           start_shuffle,
    input  logic                           start_pick,
    input  logic [N_CARDS-1:0]             sel_mask,
    input  logic [N_CARDS-1:0]             matched_mask,
    output logic [N_CARDS-1:0][CARD_W-1:0] deck,
    output logic [IDX_W-1:0]               pick_idx,
    output logic                           pick_none,
    output logic                           busy,
    output logic                           done_sh,
    output logic                           done_pick
);

    state_e                         state_r;
    state_e                         next_s;
    logic [LFSR_W-1:0]              lfsr_q;
    logic                           lfsr_load_s;
    logic [LFSR_W-1:0]              lfsr_val_s;
    logic [N_CARDS-1:0][CARD_W-1:0] deck_r;
    logic [IDX_W-1:0]               i_r;
    logic [IDX_W-1:0]               j_s;
    logic [IDX_W-1:0]               scan_r;
    logic [IDX_W-1:0]               cnt_r;
    logic [IDX_W-1:0]               start_idx_s;
    logic [IDX_W-1:0]               pick_idx_r;
    logic                           pick_none_r;
    logic                           busy_r;
    logic                           done_sh_r;
    logic                           done_pick_r;
    logic                           elig_s;
    logic                           scan_last_s;

`ifdef CARD_SEED_LOAD_EN
    assign lfsr_load_s = seed_load;
    assign lfsr_val_s  = seed_in;
`else
    assign lfsr_load_s = 1'b0;
    assign lfsr_val_s  = {LFSR_W{1'b0}};
`endif

    lfsr_gen #(.LFSR_W(LFSR_W)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load_s),
        .load_val (lfsr_val_s),
        .q        (lfsr_q)
    );

    // Swap partner, pick start index and scan-eligibility decode.
    always_comb begin
        j_s         = IDX_W'(32'(lfsr_q) % (32'(i_r) + 32'd1));
        start_idx_s = IDX_W'(32'(lfsr_q) % 32'(N_CARDS));
        elig_s      = ~(sel_mask[scan_r] | matched_mask[scan_r]);
        scan_last_s = (cnt_r == IDX_W'(N_CARDS - 1));
    end

    // Next-state logic; shuffle has priority over pick when both are requested.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_shuffle) begin
                    next_s = SHUF;
                end else if (start_pick) begin
                    next_s = PICK;
                end else begin
                    next_s = IDLE;
                end
            end
            SHUF: begin
                if (i_r == IDX_W'(1)) begin
                    next_s = DONE;
                end else begin
                    next_s = SHUF;
                end
            end
            PICK: begin
                if (elig_s || scan_last_s) begin
                    next_s = DONE;
                end else begin
                    next_s = PICK;
                end
            end
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_sh_r   <= 1'b0;
            done_pick_r <= 1'b0;
        end else begin
            state_r     <= next_s;
            busy_r      <= (next_s == SHUF) || (next_s == PICK);
            done_sh_r   <= (state_r == SHUF) && (next_s == DONE);
            done_pick_r <= (state_r == PICK) && (next_s == DONE);
        end
    end

    // Deck, shuffle counter and pick scan datapath; IDLE keeps operands primed for a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_CARDS; k++) begin
                deck_r[k] <= CARD_W'(k >> 1);
            end
            i_r         <= {IDX_W{1'b0}};
            scan_r      <= {IDX_W{1'b0}};
            cnt_r       <= {IDX_W{1'b0}};
            pick_idx_r  <= {IDX_W{1'b0}};
            pick_none_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    i_r    <= IDX_W'(N_CARDS - 1);
                    scan_r <= start_idx_s;
                    cnt_r  <= {IDX_W{1'b0}};
                end
                SHUF: begin
                    deck_r[i_r] <= deck_r[j_s];
                    deck_r[j_s] <= deck_r[i_r];
                    i_r         <= i_r - IDX_W'(1);
                end
                PICK: begin
                    if (elig_s) begin
                        pick_idx_r  <= scan_r;
                        pick_none_r <= 1'b0;
                    end else if (scan_last_s) begin
                        pick_none_r <= 1'b1;
                    end else begin
                        scan_r <= (scan_r == IDX_W'(N_CARDS - 1)) ? {IDX_W{1'b0}} : scan_r + IDX_W'(1);
                        cnt_r  <= cnt_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    cnt_r <= {IDX_W{1'b0}};
                end
                default: begin
                    cnt_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign deck      = deck_r;
    assign pick_idx  = pick_idx_r;
    assign pick_none = pick_none_r;
    assign busy      = busy_r;
    assign done_sh   = done_sh_r;
    assign done_pick = done_pick_r;

endmodule

// File: tb/tb_card_deck_engine.sv
// Randomized self-checking bench for card_deck_engine against a transaction-level deck model.
module tb_card_deck_engine;

    localparam int N  = 16;
    localparam int CW = 5;
    localparam int LW = 8;
    localparam int IW = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start_shuffle = 1'b0;
    logic                 start_pick = 1'b0;
    logic [N-1:0]         sel_mask = '0;
    logic [N-1:0]         matched_mask = '0;
    logic [N-1:0][CW-1:0] deck;
    logic [IW-1:0]        pick_idx;
    logic                 pick_none;
    logic                 busy;
    logic                 done_sh;
    logic                 done_pick;
`ifdef CARD_SEED_LOAD_EN
    logic                 seed_load = 1'b0;
    logic [LW-1:0]        seed_in = '0;
`endif

    int            n_vec = 0;
    int            n_err = 0;
    int            both_cnt = 0;
    logic [LW-1:0] lfsr_m;
    int            deck_m[N];
    logic [IW-1:0] idx_m;
    logic          none_m;

    card_deck_engine #(.N_CARDS(N), .CARD_W(CW), .LFSR_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef CARD_SEED_LOAD_EN
        .seed_load     (seed_load),
        .seed_in       (seed_in),
`endif
        .start_shuffle (start_shuffle),
        .start_pick    (start_pick),
        .sel_mask      (sel_mask),
        .matched_mask  (matched_mask),
        .deck          (deck),
        .pick_idx      (pick_idx),
        .pick_none     (pick_none),
        .busy          (busy),
        .done_sh       (done_sh),
        .done_pick     (done_pick)
    );

    always #5 clk = ~clk;

    // Polynomial x^8+x^6+x^5+x^4+1: new bit is the XOR of stages 8, 6, 5 and 4.
    function automatic logic [LW-1:0] lfsr_adv(input logic [LW-1:0] v);
        return {v[LW-2:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 8'hFE;
`ifdef CARD_SEED_LOAD_EN
        else if (seed_load) lfsr_m <= (seed_in == 8'h00) ? 8'hFE : seed_in;
`endif
        else lfsr_m <= lfsr_adv(lfsr_m);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < N; k++) deck_m[k] = k / 2;
        idx_m  = '0;
        none_m = 1'b0;
    endtask

    function automatic logic [N-1:0][CW-1:0] pack_m();
        logic [N-1:0][CW-1:0] p;
        for (int k = 0; k < N; k++) p[k] = CW'(deck_m[k]);
        return p;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_shuffle(input bit with_pick, input bit poke);
        logic [LW-1:0] l;
        int            busy_n = 0;
        int            pick_seen = 0;
        bit            got = 1'b0;
        int            j;
        int            t;
        @(negedge clk);
        start_shuffle = 1'b1;
        start_pick    = with_pick;
        l = lfsr_m;
        for (int i = N - 1; i >= 1; i--) begin
            l = lfsr_adv(l);
            j = int'(l) % (i + 1);
            t = deck_m[i]; deck_m[i] = deck_m[j]; deck_m[j] = t;
        end
        @(negedge clk);
        start_shuffle = 1'b0;
        start_pick    = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (done_sh && done_pick) both_cnt++;
            if (done_pick) pick_seen++;
            if (done_sh) got = 1'b1;
            else if (busy) busy_n++;
            if (poke) begin
                start_pick    = 1'($urandom_range(0, 1));
                start_shuffle = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start_shuffle = 1'b0;
        start_pick    = 1'b0;
        check("shuf_done", 128'(got), 128'(1));
        check("shuf_busy_cycles", 128'(busy_n), 128'(N - 1));
        check("shuf_deck", 128'(deck), 128'(pack_m()));
        check("shuf_no_pick", 128'(pick_seen), 128'(0));
        check("shuf_pick_state", 128'({pick_none, pick_idx}), 128'({none_m, idx_m}));
        check("shuf_pulse_end", 128'({busy, done_sh, done_pick}), 128'(0));
    endtask

    task automatic run_pick(input logic [N-1:0] sel, input logic [N-1:0] mat);
        int            r;
        int            exp_cycles;
        int            busy_n = 0;
        int            sh_seen = 0;
        bit            got = 1'b0;
        logic [IW-1:0] exp_idx;
        logic          exp_none;
        @(negedge clk);
        sel_mask      = sel;
        matched_mask  = mat;
        start_pick    = 1'b1;
        start_shuffle = 1'b0;
        r = int'(lfsr_m) % N;
        exp_cycles = N;
        exp_none   = 1'b1;
        exp_idx    = idx_m;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (r + k) % N;
            if (!sel[c] && !mat[c]) begin
                exp_cycles = k + 1;
                exp_none   = 1'b0;
                exp_idx    = IW'(c);
                break;
            end
        end
        @(negedge clk);
        start_pick = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (done_sh && done_pick) both_cnt++;
            if (done_sh) sh_seen++;
            if (done_pick) got = 1'b1;
            else if (busy) busy_n++;
            @(negedge clk);
        end
        idx_m  = exp_idx;
        none_m = exp_none;
        check("pick_done", 128'(got), 128'(1));
        check("pick_scan_cycles", 128'(busy_n), 128'(exp_cycles));
        check("pick_idx", 128'(pick_idx), 128'(idx_m));
        check("pick_none", 128'(pick_none), 128'(none_m));
        check("pick_deck_kept", 128'(deck), 128'(pack_m()));
        check("pick_no_sh", 128'(sh_seen), 128'(0));
        check("pick_pulse_end", 128'({busy, done_pick}), 128'(0));
    endtask

    task automatic run_abort(input bit do_pick, input int at);
        int dn = 0;
        @(negedge clk);
        if (do_pick) begin
            sel_mask     = '1;
            matched_mask = '1;
            start_pick   = 1'b1;
        end else begin
            start_shuffle = 1'b1;
        end
        @(negedge clk);
        start_pick    = 1'b0;
        start_shuffle = 1'b0;
        check("abort_busy_before", 128'(busy), 128'(1));
        repeat (at - 1) @(negedge clk);
        rst = 1'b0;
        reset_model();
        #1;
        check("abort_deck", 128'(deck), 128'(pack_m()));
        check("abort_state", 128'({busy, done_sh, done_pick, pick_none, pick_idx}), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done_sh || done_pick || busy) dn++;
        end
        check("abort_quiet", 128'(dn), 128'(0));
    endtask

    initial begin
        int dn;
        int cnt;
        logic [N-1:0] s;
        logic [N-1:0] m;
`ifdef CARD_SEED_LOAD_EN
        logic [N-1:0][CW-1:0] d1;
`endif
        reset_model();
        repeat (3) @(negedge clk);
        check("rst_deck", 128'(deck), 128'(pack_m()));
        check("rst_outs", 128'({busy, done_sh, done_pick, pick_none, pick_idx}), 128'(0));
        rst = 1'b1;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_sh || done_pick || busy) dn++;
        end
        check("idle_quiet", 128'(dn), 128'(0));
        check("idle_deck", 128'(deck), 128'(pack_m()));

        run_shuffle(1'b0, 1'b0);
        for (int v = 0; v < N / 2; v++) begin
            cnt = 0;
            for (int k = 0; k < N; k++) if (int'(deck[k]) == v) cnt++;
            check("mset", 128'(cnt), 128'(2));
        end
        run_pick(16'hFFFE, 16'h0000);
        run_pick(16'hFF00, 16'h00FF);
        run_pick(16'h0000, 16'h7FFF);
        run_shuffle(1'b1, 1'b1);
        run_abort(1'b0, 7);
        run_abort(1'b1, 5);

        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            case ($urandom_range(0, 3))
                0: run_shuffle(1'($urandom_range(0, 1)), 1'b0);
                1: run_shuffle(1'($urandom_range(0, 1)), 1'b1);
                2: begin
                    s = N'($urandom) & N'($urandom);
                    m = N'($urandom) & N'($urandom);
                    run_pick(s, m);
                end
                default: begin
                    s = N'($urandom);
                    run_pick(s, ~s);
                end
            endcase
        end

`ifdef CARD_SEED_LOAD_EN
        do_reset();
        @(negedge clk); seed_load = 1'b1; seed_in = 8'h01;
        @(negedge clk); seed_load = 1'b0;
        run_shuffle(1'b0, 1'b0);
        d1 = deck;
        do_reset();
        @(negedge clk); seed_load = 1'b1; seed_in = 8'h01;
        @(negedge clk); seed_load = 1'b0;
        run_shuffle(1'b0, 1'b0);
        check("seed_repeat", 128'(deck), 128'(d1));
`endif
        do_reset();
        #1;
        check("final_rst_deck", 128'(deck), 128'(pack_m()));
        check("done_exclusive", 128'(both_cnt), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/card_deck_engine.md
CARD_DECK_ENGINE -- requirements
Module: card_deck_engine

Interface
REQ-001 Parameter N_CARDS, default 16, SHALL be the deck size: even, 4..64.
REQ-002 Parameter CARD_W, default 5, SHALL be the card value width, with 2**CARD_W >= N_CARDS/2.
REQ-003 Parameter LFSR_W, default 8, SHALL be the pseudo-random generator width, 8 or 16.
REQ-004 Derived IDX_W = $clog2(N_CARDS) SHALL size all card indices.
REQ-005 Ports: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 start_shuffle  in  1  single-cycle request for a full deck shuffle.
REQ-009 start_pick  in  1  single-cycle request to pick one random eligible card.
REQ-010 sel_mask  in  N_CARDS  bit i=1: card i is face-up; excluded from pick.
REQ-011 matched_mask  in  N_CARDS  bit i=1: card i is already matched; excluded from pick.
REQ-012 deck  out  N_CARDS x CARD_W  current card values, index 0..N_CARDS-1.
REQ-013 pick_idx  out  IDX_W  index of the last picked card.
REQ-014 pick_none  out  1  last pick found no eligible card.
REQ-015 busy  out  1  high while SHUF or PICK is active.
REQ-016 done_sh, done_pick  out  1 each  one-cycle completion pulses.

Function
REQ-017 FSM states SHALL be IDLE, SHUF, PICK and DONE; start requests are accepted only in IDLE.
REQ-018 If both starts are high in IDLE, shuffle SHALL win and the pick request SHALL be dropped.
REQ-019 Starts arriving while busy=1 or in DONE SHALL be ignored, not queued.
REQ-020 The LFSR SHALL advance every cycle in all states; it is Fibonacci, maximal-length (x^8+x^6+x^5+x^4+1 for 8; x^16+x^15+x^13+x^4+1 for 16), never zero.
REQ-021 SHUF SHALL run Fisher-Yates: counter i from N_CARDS-1 down to 1, one swap per cycle of deck[i] with deck[j], j = lfsr mod (i+1).
REQ-022 Shuffle latency: busy SHALL rise the cycle after start; there are N_CARDS-1 swap cycles, then DONE asserts done_sh for exactly one cycle, then IDLE.
REQ-023 A shuffle SHALL preserve the deck multiset: each value 0..N_CARDS/2-1 appears exactly twice.
REQ-024 PICK SHALL scan from r = lfsr mod N_CARDS (sampled at start), one index per cycle, wrapping N_CARDS-1 -> 0.
REQ-025 A card is eligible when its bit is 0 in both sel_mask and matched_mask, sampled in the cycle it is scanned.
REQ-026 On the first eligible index, PICK SHALL load pick_idx, clear pick_none and go to DONE; latency is 1..N_CARDS scan cycles.
REQ-027 If N_CARDS indices are scanned with no hit, PICK SHALL set pick_none=1, leave pick_idx unchanged and go to DONE.
REQ-028 In DONE after a pick, done_pick SHALL assert for exactly one cycle; done_sh and done_pick are never high together.
REQ-029 The deck SHALL change only during SHUF; pick_idx and pick_none SHALL change only on pick completion.

Reset
REQ-030 On rst=0: state IDLE, deck[i]=i>>1, LFSR=all-ones except LSB=0 (8'hFE / 16'hFFFE), pick_idx=0, pick_none=0, busy=0, done_sh=0, done_pick=0.
REQ-031 Reset asserted mid-SHUF or mid-PICK SHALL abort the operation with no done pulse and restore the REQ-030 values.

Configuration
REQ-032 Macro CARD_SEED_LOAD_EN defined: ports seed_load (in, 1) and seed_in (in, LFSR_W) SHALL exist.
REQ-033 With the macro, seed_load=1 SHALL load seed_in into the LFSR next cycle; a value of 0 loads the REQ-030 value instead; seed_load has priority over advancing.
REQ-034 Macro undefined: those ports SHALL be absent and the LFSR SHALL be free-running only.

Structure
REQ-035 Package card_pkg SHALL hold the FSM state enum typedef, the LFSR reset and tap constants per width, and default N_CARDS/CARD_W.
REQ-036 Sub-module lfsr_gen (parameter LFSR_W; ports clk, rst, load, load_val, q) SHALL implement the LFSR; all other logic stays in card_deck_engine.

Verification
REQ-037 Reset then idle: deck = 0,0,1,1,...,7,7; busy=0; pick_idx=0; no done pulse within 20 cycles.
REQ-038 start_shuffle once: busy for 15 cycles, then done_sh one cycle; deck is a permutation with each of 0..7 present twice.
REQ-039 With CARD_SEED_LOAD_EN, seed 8'h01 then shuffle twice from reset: both runs SHALL give identical decks.
REQ-040 sel_mask=16'hFFFE, matched_mask=0, start_pick -> pick_idx=0, pick_none=0, done_pick within 16 cycles.
REQ-041 sel_mask|matched_mask=16'hFFFF, start_pick -> done_pick after exactly 16 scan cycles, pick_none=1, pick_idx unchanged.
REQ-042 Both starts together, start_pick repeated mid-shuffle, and rst pulsed at swap 7: shuffle only, no pick; on rst no done pulse and deck returns to reset order.
